// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: datapath hazard inputs and the pipeline sequencing outputs.
// The datapath drives through master; the controller attaches through slave.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IdValid;
  logic [4:0]       IdRs;
  logic [4:0]       IdRt;
  logic             IdUsesRt;
  logic             ExMRead;
  logic [4:0]       ExRt;
  logic             MemBranchTaken;
  logic             MemBusy;
  logic             CntClr;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXBubble;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             EXMEMFlush;
  logic             Frozen;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output IdValid, IdRs, IdRt, IdUsesRt, ExMRead, ExRt, MemBranchTaken, MemBusy, CntClr,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush, Frozen,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  IdValid, IdRs, IdRt, IdUsesRt, ExMRead, ExRt, MemBranchTaken, MemBusy, CntClr,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush, Frozen,
    output StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: load-use bubbles, taken-branch flushes,
// memory-busy freeze, plus saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, LDSTALL, FREEZE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       lu_left_q, lu_left_d;
  logic             br_pend_q, br_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic pc_wr, ifid_wr, bubble, flush, frozen;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign lu = hz.ExMRead && (hz.ExRt != 5'd0) && hz.IdValid &&
              ((hz.ExRt == hz.IdRs) || (hz.IdUsesRt && (hz.ExRt == hz.IdRt)));

  always_comb begin
    state_d   = state_q;
    lu_left_d = lu_left_q;
    br_pend_d = br_pend_q;
    pc_wr     = 1'b0;
    ifid_wr   = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    frozen    = 1'b0;

    if (hz.MemBusy) begin
      frozen  = 1'b1;
      state_d = FREEZE;
      if (hz.MemBranchTaken) br_pend_d = 1'b1;
    end else if (hz.MemBranchTaken || br_pend_q) begin
      // Wrong-path work, including any unfinished load-use stall, is dropped here.
      flush     = 1'b1;
      pc_wr     = 1'b1;
      ifid_wr   = 1'b1;
      br_pend_d = 1'b0;
      lu_left_d = 2'd0;
      state_d   = RUN;
    end else if (state_q != RUN && lu_left_q != 2'd0) begin
      // Covers both LDSTALL and a freeze that interrupted one.
      bubble    = 1'b1;
      lu_left_d = lu_left_q - 2'd1;
      state_d   = (lu_left_q == 2'd1) ? RUN : LDSTALL;
    end else if (lu) begin
      bubble = 1'b1;
      if (LU_STALL > 1) begin
        lu_left_d = 2'(LU_STALL - 1);
        state_d   = LDSTALL;
      end else begin
        state_d = RUN;
      end
    end else begin
      pc_wr   = 1'b1;
      ifid_wr = 1'b1;
      state_d = RUN;
    end

    stall_cnt_d = hz.CntClr ? '0 : (bubble ? sat_inc(stall_cnt_q) : stall_cnt_q);
    flush_cnt_d = hz.CntClr ? '0 : (flush  ? sat_inc(flush_cnt_q) : flush_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      lu_left_q   <= 2'd0;
      br_pend_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_left_q   <= lu_left_d;
      br_pend_q   <= br_pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // All strobes are held low for as long as reset is asserted.
  assign hz.PCWrite    = rst_n & pc_wr;
  assign hz.IFIDWrite  = rst_n & ifid_wr;
  assign hz.IDEXBubble = rst_n & bubble;
  assign hz.IFIDFlush  = rst_n & flush;
  assign hz.IDEXFlush  = rst_n & flush;
  assign hz.EXMEMFlush = rst_n & flush;
  assign hz.Frozen     = rst_n & frozen;
  assign hz.StallCnt   = stall_cnt_q;
  assign hz.FlushCnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a single-bubble instance (d1) and a
// three-bubble instance with 4-bit counters (d3) share one stimulus.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       IdValid, IdUsesRt, ExMRead, MemBranchTaken, MemBusy, CntClr;
  logic [4:0] IdRs, IdRt, ExRt;

  hazard_ctrl_if #(.CNT_W(16)) if1 ();
  hazard_ctrl_if #(.CNT_W(4))  if3 ();

  assign if1.IdValid = IdValid;   assign if3.IdValid = IdValid;
  assign if1.IdRs = IdRs;         assign if3.IdRs = IdRs;
  assign if1.IdRt = IdRt;         assign if3.IdRt = IdRt;
  assign if1.IdUsesRt = IdUsesRt; assign if3.IdUsesRt = IdUsesRt;
  assign if1.ExMRead = ExMRead;   assign if3.ExMRead = ExMRead;
  assign if1.ExRt = ExRt;         assign if3.ExRt = ExRt;
  assign if1.MemBranchTaken = MemBranchTaken; assign if3.MemBranchTaken = MemBranchTaken;
  assign if1.MemBusy = MemBusy;   assign if3.MemBusy = MemBusy;
  assign if1.CntClr = CntClr;     assign if3.CntClr = CntClr;

  hazard_ctrl #(.LU_STALL(1), .CNT_W(16)) d1 (.clk(clk), .rst_n(rst_n), .hz(if1));
  hazard_ctrl #(.LU_STALL(3), .CNT_W(4))  d3 (.clk(clk), .rst_n(rst_n), .hz(if3));

  // {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, IDEXFlush, EXMEMFlush, Frozen}
  wire [6:0] o1 = {if1.PCWrite, if1.IFIDWrite, if1.IDEXBubble, if1.IFIDFlush,
                   if1.IDEXFlush, if1.EXMEMFlush, if1.Frozen};
  wire [6:0] o3 = {if3.PCWrite, if3.IFIDWrite, if3.IDEXBubble, if3.IFIDFlush,
                   if3.IDEXFlush, if3.EXMEMFlush, if3.Frozen};

  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] BUBL  = 7'b0010000;
  localparam logic [6:0] FLSH  = 7'b1101110;
  localparam logic [6:0] FRZ   = 7'b0000001;
  localparam logic [6:0] ZERO  = 7'b0000000;

  typedef struct {
    string      name;
    logic       idv;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mrd;
    logic [4:0] exrt;
    logic       br;
    logic       busy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[11];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    IdValid = 1'b1; IdRs = 5'd1; IdRt = 5'd2; IdUsesRt = 1'b1;
    ExMRead = 1'b0; ExRt = 5'd5; MemBranchTaken = 1'b0; MemBusy = 1'b0; CntClr = 1'b0;
  endtask

  task automatic lu_in();
    idle();
    ExMRead = 1'b1; ExRt = 5'd5; IdRs = 5'd5;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    idle();
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_bub, exp_fl;
    tbl[0]  = '{"idle",        1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, NORM};
    tbl[1]  = '{"lu_rs",       1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, BUBL};
    tbl[2]  = '{"after_lu",    1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, NORM};
    tbl[3]  = '{"exrt_zero",   1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, NORM};
    tbl[4]  = '{"rt_unused",   1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, NORM};
    tbl[5]  = '{"lu_rt",       1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, BUBL};
    tbl[6]  = '{"id_invalid",  1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, NORM};
    tbl[7]  = '{"br_over_lu",  1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, FLSH};
    tbl[8]  = '{"busy",        1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, FRZ};
    tbl[9]  = '{"lu_from_frz", 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, BUBL};
    tbl[10] = '{"norm_end",    1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, NORM};

    // Reset state: outputs low while held, counters zero.
    idle();
    rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_out_d1", 16'(o1), 16'(ZERO));
    chk("rst_out_d3", 16'(o3), 16'(ZERO));
    chk("rst_stall_d1", if1.StallCnt, 16'd0);
    chk("rst_flush_d3", 16'(if3.FlushCnt), 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Table vectors on the single-bubble instance.
    exp_bub = 0; exp_fl = 0;
    for (int i = 0; i < 11; i++) begin
      IdValid = tbl[i].idv; IdRs = tbl[i].rs; IdRt = tbl[i].rt; IdUsesRt = tbl[i].urt;
      ExMRead = tbl[i].mrd; ExRt = tbl[i].exrt; MemBranchTaken = tbl[i].br;
      MemBusy = tbl[i].busy; CntClr = 1'b0;
      @(negedge clk);
      chk(tbl[i].name, 16'(o1), 16'(tbl[i].exp));
      if (tbl[i].exp[4]) exp_bub++;
      if (tbl[i].exp[3]) exp_fl++;
      tick();
    end
    idle();
    @(negedge clk);
    chk("tbl_stallcnt", if1.StallCnt, 16'(exp_bub));
    chk("tbl_flushcnt", if1.FlushCnt, 16'(exp_fl));

    // Single-bubble load-use: one bubble, then PCWrite back, StallCnt=1.
    rst_pulse();
    lu_in(); @(negedge clk); chk("lu1_bubble", 16'(o1), 16'(BUBL)); tick();
    idle();  @(negedge clk); chk("lu1_resume", 16'(o1), 16'(NORM));
    chk("lu1_stallcnt", if1.StallCnt, 16'd1);

    // Three-bubble load-use cut short by a taken branch after two bubbles.
    rst_pulse();
    lu_in(); @(negedge clk); chk("lu3_b1", 16'(o3), 16'(BUBL)); tick();
    idle();  @(negedge clk); chk("lu3_b2", 16'(o3), 16'(BUBL)); tick();
    MemBranchTaken = 1'b1;
    @(negedge clk); chk("lu3_flush", 16'(o3), 16'(FLSH)); tick();
    idle();  @(negedge clk); chk("lu3_after", 16'(o3), 16'(NORM));
    chk("lu3_stallcnt", 16'(if3.StallCnt), 16'd2);
    chk("lu3_flushcnt", 16'(if3.FlushCnt), 16'd1);

    // Busy for four cycles with a branch in the second: flush right after.
    rst_pulse();
    for (int c = 0; c < 4; c++) begin
      idle(); MemBusy = 1'b1; MemBranchTaken = (c == 1);
      @(negedge clk); chk($sformatf("busy_c%0d", c), 16'(o3), 16'(FRZ));
      tick();
    end
    idle(); @(negedge clk); chk("busy_flush", 16'(o3), 16'(FLSH)); tick();
    idle(); @(negedge clk); chk("busy_after", 16'(o3), 16'(NORM));
    chk("busy_flushcnt", 16'(if3.FlushCnt), 16'd1);

    // Freeze interrupting a load-use stall: bubbles resume after busy drops.
    rst_pulse();
    lu_in(); @(negedge clk); chk("frz_lu_b1", 16'(o3), 16'(BUBL)); tick();
    idle(); MemBusy = 1'b1; @(negedge clk); chk("frz_lu_f1", 16'(o3), 16'(FRZ)); tick();
    idle(); MemBusy = 1'b1; @(negedge clk); chk("frz_lu_f2", 16'(o3), 16'(FRZ)); tick();
    idle(); @(negedge clk); chk("frz_lu_b2", 16'(o3), 16'(BUBL)); tick();
    idle(); @(negedge clk); chk("frz_lu_b3", 16'(o3), 16'(BUBL)); tick();
    idle(); @(negedge clk); chk("frz_lu_run", 16'(o3), 16'(NORM));
    chk("frz_lu_stallcnt", 16'(if3.StallCnt), 16'd3);

    // 4-bit counter saturation under a sustained hazard, then clear beats bubble.
    rst_pulse();
    lu_in();
    for (int c = 0; c < 20; c++) tick();
    @(negedge clk);
    chk("sat_stallcnt", 16'(if3.StallCnt), 16'd15);
    chk("sat_bubble", 16'(o3), 16'(BUBL));
    CntClr = 1'b1; tick();
    CntClr = 1'b0; @(negedge clk);
    chk("clr_stallcnt", 16'(if3.StallCnt), 16'd0);

    // Reset asserted mid-LDSTALL: outputs drop at once, no residual bubble after.
    rst_pulse();
    lu_in(); tick();
    rst_n = 1'b0; #1;
    chk("midrst_out", 16'(o3), 16'(ZERO));
    chk("midrst_stallcnt", 16'(if3.StallCnt), 16'd0);
    idle(); #1 rst_n = 1'b1;
    @(negedge clk); chk("midrst_rel1", 16'(o3), 16'(NORM)); tick();
    @(negedge clk); chk("midrst_rel2", 16'(o3), 16'(NORM));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
